// File: rtl/wash_cycle_scheduler.sv
// wash_cycle_scheduler: sequences one washing-machine program (fill, wash, drain, rinse fill, rinse, drain, spin)
// Drives the inlet/drain valves and the drum motor from a per-program duration table and a prescaled tick.
// Handles pause/resume, abort and fill/drain timeout faults.
// Ports:
//   clk, rst (async, active-low)
//   start, pause_req, resume_req, abort, program_sel[1:0] : front-panel controls
//   level_full, level_empty                              : drum level sensors
//   valve_in_cold, valve_in_hot, valve_out, motor        : actuators (Moore, decoded from state)
//   phase[2:0], time_left[TIME_W-1:0], busy, cycle_done, fault : status
// Optional feature macro WASH_DOOR_LOCK_EN adds door_closed (in) and door_lock (out).
module wash_cycle_scheduler #(
    parameter int TICK_DIV     = 1000,
    parameter int TIME_W       = 8,
    parameter int FILL_TIMEOUT = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause_req,
    input  logic              resume_req,
    input  logic              abort,
    input  logic [1:0]        program_sel,
    input  logic              level_full,
    input  logic              level_empty,
`ifdef WASH_DOOR_LOCK_EN
    input  logic              door_closed,
    output logic              door_lock,
`endif
    output logic              valve_in_cold,
    output logic              valve_in_hot,
    output logic              valve_out,
    output logic              motor,
    output logic [2:0]        phase,
    output logic [TIME_W-1:0] time_left,
    output logic              busy,
    output logic              cycle_done,
    output logic              fault
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        DRAIN = 3'd3,
        RINSE = 3'd4,
        SPIN  = 3'd5,
        PAUSE = 3'd6,
        FAULT = 3'd7
    } state_t;

    state_t          state, state_nx, saved;
    logic [PW-1:0]   presc;
    logic [1:0]      prog;
    logic            rinse_flag, abort_flag;
    logic            running, tick, timeout, adv, enter;
    logic            start_ok, pause_go, resume_go;

`ifdef WASH_DOOR_LOCK_EN
    // An open door in a running phase behaves like a pause request.
    assign start_ok  = start & door_closed;
    assign pause_go  = pause_req | ~door_closed;
    assign resume_go = resume_req & door_closed;
    assign door_lock = busy & ~fault;
`else
    assign start_ok  = start;
    assign pause_go  = pause_req;
    assign resume_go = resume_req;
`endif

    function automatic logic [TIME_W-1:0] dur(input state_t s, input logic [1:0] p);
        logic [7:0] d;
        d = (s == WASH)  ? (p == 2'd0 ? 8'd10 : p == 2'd1 ? 8'd30 : p == 2'd2 ? 8'd45 : 8'd0) :
            (s == RINSE) ? (p == 2'd0 ? 8'd5  : p == 2'd1 ? 8'd10 : p == 2'd2 ? 8'd15 : 8'd0) :
            (s == SPIN)  ? (p == 2'd0 ? 8'd5  : p == 2'd2 ? 8'd15 : 8'd10) : 8'd0;
        return TIME_W'(d);
    endfunction

    assign running = state != IDLE && state != PAUSE && state != FAULT;
    assign tick    = running && presc == PW'(TICK_DIV - 1);
    assign timeout = tick && time_left == TIME_W'(FILL_TIMEOUT - 1);
    // Counting only continues while the phase is kept; a pausing cycle freezes the counts.
    assign adv     = running && state_nx == state;
    // Resuming is not a phase entry: prescaler and time_left carry on from where they stopped.
    assign enter   = state == PAUSE ? abort : (state_nx != state && state_nx != PAUSE);
    assign phase   = state;
    assign busy    = state != IDLE;
    assign fault   = state == FAULT;

    always_comb begin
        state_nx      = state;
        valve_in_hot  = state == FILL && prog == 2'd2 && !rinse_flag;
        valve_in_cold = state == FILL && !(prog == 2'd2 && !rinse_flag);
        valve_out     = state == DRAIN || state == SPIN;
        motor         = state == WASH || state == RINSE || state == SPIN;
        if (state == IDLE)
            state_nx = start_ok ? (program_sel == 2'd3 ? DRAIN : FILL) : IDLE;
        else if (state == FAULT)
            state_nx = abort ? IDLE : FAULT;
        else if (abort)
            state_nx = DRAIN;
        else if (state == PAUSE)
            state_nx = resume_go ? saved : PAUSE;
        else if (pause_go)
            state_nx = PAUSE;
        else if (state == FILL)
            state_nx = level_full ? (rinse_flag ? RINSE : WASH) : timeout ? FAULT : FILL;
        else if (state == DRAIN)
            state_nx = level_empty ? (abort_flag ? IDLE : (rinse_flag || prog == 2'd3) ? SPIN : FILL) :
                       timeout ? FAULT : DRAIN;
        else if (tick && time_left == TIME_W'(1))
            state_nx = state == SPIN ? IDLE : DRAIN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            saved      <= IDLE;
            prog       <= 2'd0;
            rinse_flag <= 1'b0;
            abort_flag <= 1'b0;
            presc      <= '0;
            time_left  <= '0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cycle_done <= state == SPIN && state_nx == IDLE;
            if (state != PAUSE && state_nx == PAUSE)
                saved <= state;
            if (state == IDLE && start_ok)
                prog <= program_sel;
            rinse_flag <= state_nx == IDLE ? 1'b0 : (state == DRAIN && state_nx == FILL) ? 1'b1 : rinse_flag;
            abort_flag <= state_nx == IDLE ? 1'b0 : (abort && state != IDLE) ? 1'b1 : abort_flag;
            if (enter) begin
                presc     <= '0;
                time_left <= dur(state_nx, prog);
            end else if (adv) begin
                presc <= tick ? '0 : presc + 1'b1;
                // FILL/DRAIN count elapsed ticks for the timeout; timed phases count down.
                if (tick)
                    time_left <= (state == FILL || state == DRAIN) ? time_left + 1'b1 : time_left - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wash_cycle_scheduler.sv
// tb_wash_cycle_scheduler: scoreboard bench; stimulus predicts every phase entry, a monitor checks them
module tb_wash_cycle_scheduler;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst, start, pause_req, resume_req, abort, level_full, level_empty;
    logic [1:0] program_sel;
    logic       valve_in_cold, valve_in_hot, valve_out, motor, busy, cycle_done, fault;
    logic [2:0] phase;
    logic [7:0] time_left;
    logic [5:0] outs_w;

    typedef struct {int ph; int t; int tl; int outs;} exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    exp_t cur;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   cur_p = 0;
    bit   cur_rinse = 0;
    bit   mon_en = 0;
    int   prev_ph = 0;
    int   wash_t[4]  = '{10, 30, 45, 0};
    int   rinse_t[4] = '{5, 10, 15, 0};
    int   spin_t[4]  = '{5, 10, 15, 10};

    wash_cycle_scheduler #(.TICK_DIV(TD), .TIME_W(8), .FILL_TIMEOUT(60)) dut (
        .clk(clk), .rst(rst), .start(start), .pause_req(pause_req), .resume_req(resume_req),
        .abort(abort), .program_sel(program_sel), .level_full(level_full), .level_empty(level_empty),
        .valve_in_cold(valve_in_cold), .valve_in_hot(valve_in_hot), .valve_out(valve_out),
        .motor(motor), .phase(phase), .time_left(time_left), .busy(busy),
        .cycle_done(cycle_done), .fault(fault)
    );

    assign outs_w = {valve_in_cold, valve_in_hot, valve_out, motor, busy, fault};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Actuator/status vector {cold, hot, out, motor, busy, fault} that the phase table demands.
    function automatic int outs_of(input int ph);
        bit hot  = ph == 1 && cur_p == 2 && !cur_rinse;
        bit cold = ph == 1 && !hot;
        bit vout = ph == 3 || ph == 5;
        bit mot  = ph == 2 || ph == 4 || ph == 5;
        return {26'd0, cold, hot, vout, mot, ph != 0, ph == 7};
    endfunction

    task automatic push_exp(input int ph, input int t, input int tl);
        exp_q.push_back('{ph, t, tl, outs_of(ph)});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step;
    endtask

    // Sensor-terminated phase: sensor pulsed d cycles after entry, next phase one cycle later.
    task automatic sens(input bit full, input int d, input int nxt, input int nxt_tl);
        int e = cyc;
        goto(e + d);
        if (full) level_full = 1'b1;
        else level_empty = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            start = 1'b1;
            program_sel = 2'($urandom);
        end
        push_exp(nxt, cyc + 1, nxt_tl);
        step;
        level_full = 1'b0;
        level_empty = 1'b0;
        start = 1'b0;
    endtask

    // Timed phase of d ticks, optionally paused after k counted cycles for plen cycles.
    task automatic timed(input int ph, input int d, input int nxt, input int nxt_tl,
                         input bit pz, input int k, input int plen);
        int e  = cyc;
        int kk = k % (TD * d);
        int t  = e + TD * d;
        if (pz) begin
            goto(e + kk);
            pause_req = 1'b1;
            push_exp(6, cyc + 1, d - kk / TD);
            step;
            pause_req = 1'b0;
            goto(cyc + plen - 1);
            resume_req = 1'b1;
            push_exp(ph, cyc + 1, d - kk / TD);
            step;
            resume_req = 1'b0;
            t = cyc + TD * d - kk;
        end
        push_exp(nxt, t, nxt_tl);
        if (nxt == 0) done_q.push_back(t);
        goto(t);
    endtask

    task automatic begin_prog(input int p);
        cur_p = p;
        cur_rinse = 0;
        start = 1'b1;
        program_sel = 2'(p);
        push_exp(p == 3 ? 3 : 1, cyc + 1, 0);
        step;
        start = 1'b0;
    endtask

    // pz_sel: 0 pause in WASH, 1 in RINSE, 2 in SPIN, 3 no pause.
    task automatic run_prog(input int p, input int pz_sel, input int k, input int plen, input int fd);
        begin_prog(p);
        if (p == 3) begin
            sens(0, $urandom_range(0, 8), 5, spin_t[3]);
            timed(5, spin_t[3], 0, 0, pz_sel == 2, k, plen);
        end else begin
            sens(1, fd, 2, wash_t[p]);
            timed(2, wash_t[p], 3, 0, pz_sel == 0, k, plen);
            cur_rinse = 1;
            sens(0, $urandom_range(0, 8), 1, 0);
            sens(1, $urandom_range(0, 8), 4, rinse_t[p]);
            timed(4, rinse_t[p], 3, 0, pz_sel == 1, k, plen);
            sens(0, $urandom_range(0, 8), 5, spin_t[p]);
            timed(5, spin_t[p], 0, 0, pz_sel == 2, k, plen);
        end
        cur_rinse = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(phase) != prev_ph) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_phase: got %0d with nothing expected (cycle %0d)", phase, cyc);
                end else begin
                    cur = exp_q.pop_front();
                    chk("phase", phase, cur.ph);
                    chk("entry_cycle", cyc, cur.t);
                    chk("time_left", time_left, cur.tl);
                    chk("outputs", outs_w, cur.outs);
                end
                prev_ph = phase;
            end else if (phase == 3'd6) begin
                chk("pause_time_left", time_left, cur.tl);
                chk("pause_outputs", outs_w, cur.outs);
            end
            if (cycle_done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_cycle_done: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("cycle_done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        pause_req = 1'b0;
        resume_req = 1'b0;
        abort = 1'b0;
        level_full = 1'b0;
        level_empty = 1'b0;
        program_sel = 2'd0;
        step;
        step;
        chk("reset_phase", phase, 0);
        chk("reset_outputs", outs_w, 0);
        chk("reset_time_left", time_left, 0);
        chk("reset_cycle_done", cycle_done, 0);
        rst = 1'b1;
        step;
        prev_ph = 0;
        mon_en = 1;
        run_prog(0, 3, 0, 1, 3);
        run_prog(2, 3, 0, 1, 2);
        run_prog(0, 0, 12, 50, 1);
        run_prog(3, 2, 9, 7, 0);
        for (int i = 0; i < 6; i++)
            run_prog($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 200),
                     $urandom_range(1, 20), $urandom_range(0, 8));
        begin_prog(1);
        push_exp(7, cyc + 60 * TD, 0);
        goto(cyc + 60 * TD + 5);
        abort = 1'b1;
        push_exp(0, cyc + 1, 0);
        step;
        abort = 1'b0;
        begin_prog(0);
        sens(1, 2, 2, 10);
        timed(2, 10, 3, 0, 1'b0, 0, 1);
        cur_rinse = 1;
        sens(0, 1, 1, 0);
        sens(1, 1, 4, 5);
        goto(cyc + 6);
        abort = 1'b1;
        pause_req = 1'b1;
        push_exp(3, cyc + 1, 0);
        step;
        abort = 1'b0;
        pause_req = 1'b0;
        sens(0, 3, 0, 0);
        cur_rinse = 0;
        begin_prog(1);
        sens(1, 3, 2, 30);
        goto(cyc + 20);
        push_exp(0, cyc, 0);
        rst = 1'b0;
        step;
        chk("midwash_reset_phase", phase, 0);
        chk("midwash_reset_outputs", outs_w, 0);
        chk("midwash_reset_time_left", time_left, 0);
        rst = 1'b1;
        step;
        run_prog(1, 1, 21, 5, 4);
        repeat (5) step;
        chk("expected_left_in_queue", exp_q.size(), 0);
        chk("done_left_in_queue", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
